// File: rtl/sw_pkg.sv
// Shared types and constants for the Smith-Waterman front end: base codes, ASCII
// constants, streamer FSM states and the decoded-character record.
package sw_pkg;

    typedef logic [1:0] base_t;

    localparam base_t BASE_A = 2'b00;
    localparam base_t BASE_G = 2'b01;
    localparam base_t BASE_T = 2'b10;
    localparam base_t BASE_C = 2'b11;

    localparam logic [7:0] CH_GT = 8'h3E;
    localparam logic [7:0] CH_LF = 8'h0A;
    localparam logic [7:0] CH_CR = 8'h0D;
    localparam logic [7:0] CH_SP = 8'h20;

    typedef enum logic [2:0] {
        S_IDLE,
        S_QHDR,
        S_QSEQ,
        S_DHDR,
        S_DSEQ,
        S_FLUSH,
        S_GAP
    } fsb_state_t;

    typedef struct packed {
        logic  is_base;
        logic  is_hdr;
        logic  is_eol;
        base_t base;
    } fsb_char_t;

    // States in which the byte interface is stalled and the decoder output is frozen.
    function automatic logic is_stall_state(fsb_state_t s);
        return (s == S_FLUSH) || (s == S_GAP);
    endfunction

endpackage

// File: rtl/fsb_char_decoder.sv
// Registered ASCII classifier for the FASTA streamer (one pipeline stage).
// FSB_IUPAC_N_EN: when defined, 'N'/'n' decode as base A instead of being dropped.
module fsb_char_decoder
    import sw_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] byte_in,
    input  logic       accept,
    input  logic       byte_last,
    input  logic       hold,
    output logic       dec_vld,
    output logic       dec_last,
    output fsb_char_t  dec
);

    fsb_char_t cls_d, cls_q;
    logic      vld_q, last_q;

    always_comb begin
        cls_d = '0;
        case (byte_in)
            CH_GT:        cls_d.is_hdr = 1'b1;
            CH_LF:        cls_d.is_eol = 1'b1;
            CH_CR, CH_SP: cls_d = '0;
            "A", "a":     begin cls_d.is_base = 1'b1; cls_d.base = BASE_A; end
            "G", "g":     begin cls_d.is_base = 1'b1; cls_d.base = BASE_G; end
            "T", "t":     begin cls_d.is_base = 1'b1; cls_d.base = BASE_T; end
            "C", "c":     begin cls_d.is_base = 1'b1; cls_d.base = BASE_C; end
`ifdef FSB_IUPAC_N_EN
            "N", "n":     begin cls_d.is_base = 1'b1; cls_d.base = BASE_A; end
`endif
            default:      cls_d = '0;
        endcase
    end

    // Entry stays put while the FSM is stalled; the byte interface is closed then.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_q  <= 1'b0;
            last_q <= 1'b0;
            cls_q  <= '0;
        end else if (accept) begin
            vld_q  <= 1'b1;
            last_q <= byte_last;
            cls_q  <= cls_d;
        end else if (!hold) begin
            vld_q  <= 1'b0;
        end
    end

    assign dec_vld  = vld_q;
    assign dec_last = last_q;
    assign dec      = cls_q;

endmodule

// File: rtl/fasta_base_streamer.sv
// FASTA parser front end: packs the first record as the query and streams later records
// one base per cycle to the scorer. Optional macro FSB_IUPAC_N_EN accepts 'N' as a base.
module fasta_base_streamer
    import sw_pkg::*;
#(
    parameter int unsigned STRING_LENGTH = 50,
    parameter int unsigned CNT_WIDTH     = 12,
    parameter int unsigned ID_WIDTH      = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [7:0]                   byte_in,
    input  logic                         byte_vld,
    input  logic                         byte_last,
    output logic                         byte_rdy,
    output logic [0:2*STRING_LENGTH-1]   query,
    output logic [6:0]                   query_length,
    output logic                         query_vld,
    output logic                         query_ovf,
    output logic [1:0]                   data_out,
    output logic                         en_out,
    output logic [CNT_WIDTH-1:0]         counter_out,
    output logic [ID_WIDTH-1:0]          seq_id,
    output logic                         seq_last
);

    localparam int unsigned QW = $clog2(STRING_LENGTH + 1);
    localparam logic [QW-1:0] QMAX = QW'(STRING_LENGTH);

    fsb_state_t                 state_d, state_q;
    logic                       rdy_d, rdy_q;
    logic [0:2*STRING_LENGTH-1] query_d, query_q;
    logic [QW-1:0]              qcnt_d, qcnt_q;
    logic [6:0]                 qlen_d, qlen_q;
    logic                       qvld_d, qvld_q;
    logic                       qovf_d, qovf_q;
    base_t                      hold_d, hold_q;
    logic                       hold_vld_d, hold_vld_q;
    logic [CNT_WIDTH-1:0]       idx_d, idx_q;
    logic                       term_last_d, term_last_q;
    logic [ID_WIDTH-1:0]        seq_id_d, seq_id_q;
    base_t                      data_d, data_q;
    logic [CNT_WIDTH-1:0]       cnt_out_d, cnt_out_q;
    logic                       en_d, en_q;
    logic                       seq_last_d, seq_last_q;

    logic      dec_vld, dec_last, consume, term;
    fsb_char_t dec;

    fsb_char_decoder u_decoder (
        .clk       (clk),
        .rst       (rst),
        .byte_in   (byte_in),
        .accept    (byte_vld && rdy_q),
        .byte_last (byte_last),
        .hold      (is_stall_state(state_q)),
        .dec_vld   (dec_vld),
        .dec_last  (dec_last),
        .dec       (dec)
    );

    assign consume = dec_vld && !is_stall_state(state_q);
    assign term    = consume && (dec.is_hdr || dec_last);
    assign rdy_d   = !is_stall_state(state_d);

    always_comb begin
        state_d     = state_q;
        query_d     = query_q;
        qcnt_d      = qcnt_q;
        qlen_d      = qlen_q;
        qvld_d      = qvld_q;
        qovf_d      = qovf_q;
        hold_d      = hold_q;
        hold_vld_d  = hold_vld_q;
        idx_d       = idx_q;
        term_last_d = term_last_q;
        seq_id_d    = seq_id_q;
        data_d      = data_q;
        cnt_out_d   = cnt_out_q;
        en_d        = 1'b0;
        seq_last_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (consume && dec.is_hdr && !dec_last) begin
                    state_d = S_QHDR;
                    query_d = '0;
                    qcnt_d  = '0;
                    qovf_d  = 1'b0;
                end
            end
            S_QHDR: begin
                if (consume) begin
                    if (dec_last)        state_d = S_IDLE;
                    else if (dec.is_eol) state_d = S_QSEQ;
                end
            end
            S_QSEQ: begin
                if (consume && dec.is_base) begin
                    if (qcnt_q < QMAX) begin
                        query_d[{qcnt_q, 1'b0} +: 2] = dec.base;
                        qcnt_d = qcnt_q + 1'b1;
                    end else begin
                        qovf_d = 1'b1;
                    end
                end
                if (term) begin
                    qvld_d  = 1'b1;
                    qlen_d  = 7'(qcnt_d) - 7'd1;
                    state_d = dec_last ? S_IDLE : S_DHDR;
                end
            end
            S_DHDR: begin
                if (consume) begin
                    if (dec_last)        state_d = S_IDLE;
                    else if (dec.is_eol) state_d = S_DSEQ;
                end
            end
            S_DSEQ: begin
                // A new base pushes the previously held one out to the scorer.
                if (consume && dec.is_base) begin
                    if (hold_vld_q) begin
                        en_d      = 1'b1;
                        data_d    = hold_q;
                        cnt_out_d = idx_q;
                        idx_d     = (idx_q == '1) ? idx_q : idx_q + 1'b1;
                    end
                    hold_d     = dec.base;
                    hold_vld_d = 1'b1;
                end
                if (term) begin
                    term_last_d = dec_last;
                    if (hold_vld_d) begin
                        state_d = S_FLUSH;
                    end else begin
                        seq_id_d = seq_id_q + 1'b1;
                        state_d  = dec_last ? S_IDLE : S_DHDR;
                    end
                end
            end
            S_FLUSH: begin
                en_d       = 1'b1;
                data_d     = hold_q;
                cnt_out_d  = idx_q;
                seq_last_d = 1'b1;
                hold_vld_d = 1'b0;
                state_d    = S_GAP;
            end
            S_GAP: begin
                seq_id_d = seq_id_q + 1'b1;
                idx_d    = '0;
                state_d  = term_last_q ? S_IDLE : S_DHDR;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            rdy_q       <= 1'b0;
            query_q     <= '0;
            qcnt_q      <= '0;
            qlen_q      <= '0;
            qvld_q      <= 1'b0;
            qovf_q      <= 1'b0;
            hold_q      <= BASE_A;
            hold_vld_q  <= 1'b0;
            idx_q       <= '0;
            term_last_q <= 1'b0;
            seq_id_q    <= '0;
            data_q      <= BASE_A;
            cnt_out_q   <= '0;
            en_q        <= 1'b0;
            seq_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            rdy_q       <= rdy_d;
            query_q     <= query_d;
            qcnt_q      <= qcnt_d;
            qlen_q      <= qlen_d;
            qvld_q      <= qvld_d;
            qovf_q      <= qovf_d;
            hold_q      <= hold_d;
            hold_vld_q  <= hold_vld_d;
            idx_q       <= idx_d;
            term_last_q <= term_last_d;
            seq_id_q    <= seq_id_d;
            data_q      <= data_d;
            cnt_out_q   <= cnt_out_d;
            en_q        <= en_d;
            seq_last_q  <= seq_last_d;
        end
    end

    assign byte_rdy     = rdy_q;
    assign query        = query_q;
    assign query_length = qlen_q;
    assign query_vld    = qvld_q;
    assign query_ovf    = qovf_q;
    assign data_out     = data_q;
    assign en_out       = en_q;
    assign counter_out  = cnt_out_q;
    assign seq_id       = seq_id_q;
    assign seq_last     = seq_last_q;

endmodule

// File: tb/tb_fasta_base_streamer.sv
// Bench for fasta_base_streamer: FASTA files built from abstract records, expected
// outputs derived from those records, plus directed files with literal expectations.
module tb_fasta_base_streamer;

    localparam int SL = 50;
    localparam int CW = 12;
    localparam int IW = 8;

    typedef struct packed {
        logic [1:0]    base;
        logic [CW-1:0] cnt;
        logic [IW-1:0] id;
        logic          last;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [7:0]        byte_in = 8'h00;
    logic              byte_vld = 1'b0;
    logic              byte_last = 1'b0;
    logic              byte_rdy;
    logic [0:2*SL-1]   query;
    logic [6:0]        query_length;
    logic              query_vld, query_ovf;
    logic [1:0]        data_out;
    logic              en_out;
    logic [CW-1:0]     counter_out;
    logic [IW-1:0]     seq_id;
    logic              seq_last;

    int checks = 0;
    int failures = 0;
    bit abort = 1'b0;
    bit gap_en = 1'b0;

    exp_t            exp_q[$];
    logic [7:0]      file_q[$];
    logic [1:0]      seq_q[$];
    logic [0:2*SL-1] mq;
    logic [6:0]      mlen;
    logic            movf;

    logic [7:0] junk_tab [0:7] = '{8'h78, 8'h31, 8'h2D, 8'h20, 8'h0D, 8'h2A, 8'h4E, 8'h6E};
    logic [7:0] name_tab [0:7] = '{8'h41, 8'h43, 8'h67, 8'h74, 8'h30, 8'h37, 8'h5F, 8'h20};
`ifdef FSB_IUPAC_N_EN
    localparam int JMAX = 5;
`else
    localparam int JMAX = 7;
`endif

    fasta_base_streamer #(
        .STRING_LENGTH (SL),
        .CNT_WIDTH     (CW),
        .ID_WIDTH      (IW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .byte_in      (byte_in),
        .byte_vld     (byte_vld),
        .byte_last    (byte_last),
        .byte_rdy     (byte_rdy),
        .query        (query),
        .query_length (query_length),
        .query_vld    (query_vld),
        .query_ovf    (query_ovf),
        .data_out     (data_out),
        .en_out       (en_out),
        .counter_out  (counter_out),
        .seq_id       (seq_id),
        .seq_last     (seq_last)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Stream monitor: every en_out pulse must be the next expected base.
    bit   prev_last = 1'b0;
    exp_t mon_e;
    always @(negedge clk) begin
        if (rst) begin
            if (prev_last) chk("gap_after_last", en_out, 1'b0);
            if (en_out) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL extra_base: got base %0d cnt %0d id %0d, none expected",
                             data_out, counter_out, seq_id);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("stream", {data_out, counter_out, seq_id, seq_last}, mon_e);
                end
            end
            prev_last = en_out && seq_last;
        end else begin
            prev_last = 1'b0;
        end
    end

    task automatic push_exp(input logic [1:0] b, input int c, input int id, input logic l);
        exp_t e;
        e.base = b;
        e.cnt  = CW'(c);
        e.id   = IW'(id);
        e.last = l;
        exp_q.push_back(e);
    endtask

    task automatic push_str(input string s);
        for (int i = 0; i < s.len(); i++) file_q.push_back(s[i]);
    endtask

    task automatic send(input logic [7:0] b, input logic last);
        int n;
        if (abort) return;
        byte_in   = b;
        byte_vld  = 1'b1;
        byte_last = last;
        n = 0;
        @(negedge clk);
        while (!byte_rdy && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (!byte_rdy) begin
            checks++;
            failures++;
            $display("FAIL byte_rdy_timeout: byte_rdy=0 for %0d cycles, required 1", n);
            abort = 1'b1;
        end else begin
            @(posedge clk);
            #1;
        end
        byte_vld  = 1'b0;
        byte_last = 1'b0;
        if (gap_en && $urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
        end
    endtask

    task automatic send_file(input bit with_last);
        for (int i = 0; i < file_q.size(); i++)
            send(file_q[i], with_last && (i == file_q.size() - 1));
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        rst = 1'b0;
        byte_vld = 1'b0;
        byte_last = 1'b0;
        #1;
        chk("rst_byte_rdy", byte_rdy, 1'b0);
        chk("rst_en_out", en_out, 1'b0);
        chk("rst_data_out", data_out, 2'b0);
        chk("rst_counter", counter_out, '0);
        chk("rst_seq_id", seq_id, '0);
        chk("rst_seq_last", seq_last, 1'b0);
        chk("rst_query", query, '0);
        chk("rst_qlen", query_length, '0);
        chk("rst_qvld", query_vld, 1'b0);
        chk("rst_qovf", query_ovf, 1'b0);
        exp_q.delete();
        file_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("rdy_before_first_edge", byte_rdy, 1'b0);
        @(posedge clk);
        #1;
        chk("rdy_after_reset", byte_rdy, 1'b1);
    endtask

    task automatic end_check(input string tag);
        repeat (12) @(posedge clk);
        #1;
        chk({tag, "_drain"}, exp_q.size(), 0);
        chk({tag, "_query"}, query, mq);
        chk({tag, "_qlen"}, query_length, mlen);
        chk({tag, "_qvld"}, query_vld, 1'b1);
        chk({tag, "_qovf"}, query_ovf, movf);
    endtask

    // ---------------- record-level model and file rendering ----------------
    function automatic logic [7:0] base_ch(input logic [1:0] b);
        logic [7:0] s;
        case (b)
            2'b00:   s = 8'h41;
            2'b01:   s = 8'h47;
            2'b10:   s = 8'h54;
            default: s = 8'h43;
        endcase
        if ($urandom_range(0, 1) == 1) s = s + 8'h20;
`ifdef FSB_IUPAC_N_EN
        if (b == 2'b00 && $urandom_range(0, 3) == 0) s = ($urandom_range(0, 1) == 1) ? 8'h4E : 8'h6E;
`endif
        return s;
    endfunction

    task automatic gen_seq(input int n);
        seq_q.delete();
        repeat (n) seq_q.push_back(2'($urandom_range(0, 3)));
    endtask

    task automatic add_header();
        file_q.push_back(8'h3E);
        repeat ($urandom_range(1, 6)) file_q.push_back(name_tab[$urandom_range(0, 7)]);
        file_q.push_back(8'h0A);
    endtask

    task automatic render_seq();
        foreach (seq_q[i]) begin
            if ($urandom_range(0, 9) == 0) file_q.push_back(junk_tab[$urandom_range(0, JMAX)]);
            file_q.push_back(base_ch(seq_q[i]));
            if ($urandom_range(0, 11) == 0) begin
                if ($urandom_range(0, 1) == 1) file_q.push_back(8'h0D);
                file_q.push_back(8'h0A);
            end
        end
        file_q.push_back(8'h0A);
    endtask

    task automatic model_query();
        int n;
        n = (seq_q.size() > SL) ? SL : seq_q.size();
        mq = '0;
        for (int i = 0; i < n; i++) mq[2*i +: 2] = seq_q[i];
        mlen = 7'(n - 1);
        movf = seq_q.size() > SL;
    endtask

    task automatic model_db(input int j);
        int n;
        n = seq_q.size();
        for (int k = 0; k < n; k++)
            push_exp(seq_q[k], (k > (1 << CW) - 1) ? (1 << CW) - 1 : k, j % (1 << IW), k == n - 1);
    endtask

    task automatic add_db(input int j, input int len);
        gen_seq(len);
        add_header();
        render_seq();
        model_db(j);
    endtask

    task automatic run_random(input string tag, input int qlen, input int ndb, input int maxlen);
        file_q.delete();
        gen_seq(qlen);
        add_header();
        render_seq();
        model_query();
        for (int j = 0; j < ndb; j++) add_db(j, $urandom_range(0, maxlen));
        if ($urandom_range(0, 1) == 1)
            while (file_q.size() > 1 && (file_q[$] == 8'h0A || file_q[$] == 8'h0D))
                void'(file_q.pop_back());
        send_file(1'b1);
        end_check(tag);
    endtask

    initial begin
        #1_000_000;
        failures++;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        do_reset();

        // Query AGTC, one DB record AC.
        push_str(">q\nAGTC\n>d0\nAC\n");
        push_exp(2'b00, 0, 0, 1'b0);
        push_exp(2'b11, 1, 0, 1'b1);
        mq = '0;
        mq[0:7] = 8'b00011011;
        mlen = 7'd3;
        movf = 1'b0;
        send_file(1'b1);
        end_check("t1");
        chk("t1_seq_id_after", seq_id, 8'd1);

        // Two DB records with a gap between them.
        do_reset();
        push_str(">q\nA\n>a\nGG\n>b\nT\n");
        push_exp(2'b01, 0, 0, 1'b0);
        push_exp(2'b01, 1, 0, 1'b1);
        push_exp(2'b10, 0, 1, 1'b1);
        mq = '0;
        mlen = 7'd0;
        movf = 1'b0;
        send_file(1'b1);
        end_check("t2");

        // Unknown character and CR inside a DB line.
        do_reset();
        push_str(">q\nA\n>d\nAN\r\nC\n");
        push_exp(2'b00, 0, 0, 1'b0);
`ifdef FSB_IUPAC_N_EN
        push_exp(2'b00, 1, 0, 1'b0);
        push_exp(2'b11, 2, 0, 1'b1);
`else
        push_exp(2'b11, 1, 0, 1'b1);
`endif
        send_file(1'b1);
        end_check("t4");

        // Query overflow.
        do_reset();
        run_random("t3", 60, 1, 10);
        chk("t3_qlen_lit", query_length, 7'd49);
        chk("t3_qovf_lit", query_ovf, 1'b1);

        // Reset in the middle of a DB record, then a clean file.
        do_reset();
        push_str(">q\nAC\n>d\nGTCA");
        push_exp(2'b01, 0, 0, 1'b0);
        push_exp(2'b10, 1, 0, 1'b0);
        push_exp(2'b11, 2, 0, 1'b0);
        send_file(1'b0);
        repeat (6) @(posedge clk);
        #1;
        chk("t5_emitted_before_reset", exp_q.size(), 0);
        chk("t5_qlen", query_length, 7'd1);
        do_reset();
        run_random("t5_restart", 8, 2, 12);

        // Random files with byte_vld gaps.
        gap_en = 1'b1;
        for (int f = 0; f < 6; f++) begin
            do_reset();
            run_random($sformatf("rand%0d", f), $urandom_range(1, 60), $urandom_range(0, 4), 30);
        end
        gap_en = 1'b0;

        // seq_id wrap: 260 empty records, then one with bases (id 4).
        do_reset();
        gen_seq(5);
        add_header();
        render_seq();
        model_query();
        for (int j = 0; j < 260; j++) add_db(j, 0);
        add_db(260, 3);
        send_file(1'b1);
        end_check("wrap");

        // counter_out saturation on a long record.
        do_reset();
        gen_seq(3);
        add_header();
        render_seq();
        model_query();
        add_db(0, 4100);
        send_file(1'b1);
        end_check("sat");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
